// File: rtl/alu_pkg.sv
// Shared FSM encoding and default sizing for the adder response checker.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_LATENCY = 2;
  localparam int DEF_N_VEC   = 8;
  localparam int DL_W        = 6;

endpackage

// File: rtl/resp_delay_line.sv
// Fixed-depth shift register that aligns expected results with the core output.
module resp_delay_line #(
  parameter int LATENCY = 2,
  parameter int W       = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [LATENCY];

  // Shift one stage per cycle; flush zeroes every stage so stale entries never compare.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[LATENCY-1];

endmodule

// File: rtl/adder_resp_checker.sv
// Checks a full-adder core against an inline reference over a run of N_VEC vectors.
//
// state | meaning
// IDLE  | waiting for start, results held
// CHECK | accepting stimulus, comparing delayed expectations
// DONE  | one-cycle done pulse, then back to IDLE
module adder_resp_checker
  import alu_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int N_VEC   = DEF_N_VEC,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stim_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  input  logic             s_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [4:0]       fail_vec
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       LAST_VEC = 8'(N_VEC - 1);

  state_t          state;
  logic [7:0]      vec_cnt;
  logic            exp_s;
  logic            exp_c;
  logic [DL_W-1:0] dl_in;
  logic [DL_W-1:0] dl_out;
  logic            flush;
  logic            cmp_en;
  logic            mismatch;

  // Reference full adder; only CHECK-state stimulus enters the delay line.
  always_comb begin
    exp_s = in_a ^ in_b ^ in_c;
    exp_c = (in_a & in_b) | (in_b & in_c) | (in_a & in_c);
    dl_in = '0;
    if (state == CHECK && stim_valid) dl_in = {1'b1, exp_s, exp_c, in_a, in_b, in_c};
  end

  assign flush    = (state == IDLE) && start;
  assign cmp_en   = (state == CHECK) && dl_out[5];
  assign mismatch = (dl_out[4:3] != {s_in, c_in});

  resp_delay_line #(
    .LATENCY (LATENCY),
    .W       (DL_W)
  ) u_dl (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .din   (dl_in),
    .dout  (dl_out)
  );

  // Run control and result registers; counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      fail_vec <= '0;
      vec_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CHECK;
            busy     <= 1'b1;
            err      <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            fail_vec <= '0;
            vec_cnt  <= '0;
          end
        end
        CHECK: begin
          if (cmp_en) begin
            if (mismatch) begin
              err <= 1'b1;
              if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
              if (!err) fail_vec <= {dl_out[2:0], s_in, c_in};
            end else begin
              if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
            end
            vec_cnt <= vec_cnt + 8'd1;
            if (vec_cnt == LAST_VEC) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_resp_checker.sv
// Scoreboard bench for adder_resp_checker: default instance plus a small saturating one.
module tb_adder_resp_checker;

  typedef struct {
    logic [7:0] pass;
    logic [7:0] fail;
    logic       err;
    logic [4:0] fv;
  } exp_t;

  logic clk;
  logic rst, start, start1, stim_valid;
  logic in_a, in_b, in_c;
  logic s_core, c_core, s_core1, c_core1;
  logic a1, b1, c1;
  logic busy, done, err;
  logic [7:0] pass_cnt, fail_cnt;
  logic [4:0] fail_vec;
  logic busy1, done1, err1;
  logic [1:0] pass_cnt1, fail_cnt1;
  logic [4:0] fail_vec1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int busy_drop = 0;
  bit sel = 0;
  int fault = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  logic [2:0] fault_order [8] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  adder_resp_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .stim_valid(stim_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .s_in(s_core), .c_in(c_core),
    .busy(busy), .done(done), .err(err),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_vec(fail_vec)
  );

  adder_resp_checker #(.LATENCY(2), .N_VEC(6), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start1), .stim_valid(stim_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .s_in(s_core1), .c_in(c_core1),
    .busy(busy1), .done(done1), .err(err1),
    .pass_cnt(pass_cnt1), .fail_cnt(fail_cnt1), .fail_vec(fail_vec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage adder core model: input sync flop then result register.
  always @(posedge clk) begin
    a1 <= in_a;
    b1 <= in_b;
    c1 <= in_c;
    s_core  <= (fault == 1) ? 1'b0 : (a1 ^ b1 ^ c1);
    c_core  <= (a1 & b1) | (b1 & c1) | (a1 & c1);
    s_core1 <= ~(a1 ^ b1 ^ c1);
    c_core1 <= ~((a1 & b1) | (b1 & c1) | (a1 & c1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected run result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_done", 1, 0);
      end else begin
        e0 = q0.pop_front();
        check("dut0_pass_cnt", pass_cnt, e0.pass);
        check("dut0_fail_cnt", fail_cnt, e0.fail);
        check("dut0_err", err, e0.err);
        check("dut0_fail_vec", fail_vec, e0.fv);
        check("dut0_busy_at_done", busy, 0);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_done", 1, 0);
      end else begin
        e1 = q1.pop_front();
        check("dut1_pass_cnt", pass_cnt1, e1.pass);
        check("dut1_fail_cnt", fail_cnt1, e1.fail);
        check("dut1_err", err1, e1.err);
        check("dut1_fail_vec", fail_vec1, e1.fv);
        check("dut1_busy_at_done", busy1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_run(input bit s1);
    sel = s1;
    busy_drop = 0;
    t0 = cyc;
    if (s1) start1 = 1'b1; else start = 1'b1;
    tick();
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send(input logic [2:0] v);
    if ((sel ? busy1 : busy) !== 1'b1) busy_drop++;
    stim_valid = 1'b1;
    {in_a, in_b, in_c} = v;
    tick();
    stim_valid = 1'b0;
    {in_a, in_b, in_c} = 3'b000;
  endtask

  task automatic wait_done(input int exp_ticks);
    int n;
    n = 0;
    while (((sel ? done1 : done) !== 1'b1) && n < 100) begin
      if ((sel ? busy1 : busy) !== 1'b1) busy_drop++;
      tick();
      n++;
    end
    check("done_seen", sel ? done1 : done, 1);
    check("done_cycle", cyc - t0, exp_ticks);
    check("busy_held", busy_drop, 0);
    tick();
    check("done_one_cycle", sel ? done1 : done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; stim_valid = 1'b0;
    in_a = 1'b0; in_b = 1'b0; in_c = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_counts", {pass_cnt, fail_cnt}, 0);
    check("rst_fail_vec", fail_vec, 0);
    check("rst_dut1_all", {busy1, done1, err1, pass_cnt1, fail_cnt1, fail_vec1}, 0);
    rst = 1'b0;
    tick();

    // Exhaustive, back-to-back vectors with a correct core.
    q0.push_back('{8'd8, 8'd0, 1'b0, 5'd0});
    start_run(0);
    for (int i = 0; i < 8; i++) send(3'(i));
    wait_done(11);
    tick();
    check("idle_hold_pass", pass_cnt, 8);
    check("idle_busy", busy, 0);

    // Sum stuck at zero; a=1,b=0,c=0 goes first.
    fault = 1;
    q0.push_back('{8'd4, 8'd4, 1'b1, 5'b10000});
    start_run(0);
    for (int i = 0; i < 8; i++) send(fault_order[i]);
    wait_done(11);
    fault = 0;
    tick();

    // Gapped stimulus: each compare lands exactly two cycles after accept.
    q0.push_back('{8'd8, 8'd0, 1'b0, 5'd0});
    start_run(0);
    for (int k = 0; k < 8; k++) begin
      send(3'(k));
      check("gap_pass_after_accept", pass_cnt, k);
      if (busy !== 1'b1) busy_drop++;
      tick();
      check("gap_pass_before_cmp", pass_cnt, k);
    end
    wait_done(18);
    tick();

    // Reset after three compares aborts the run silently.
    start_run(0);
    for (int i = 0; i < 5; i++) send(3'(i));
    check("mid_pass_before_rst", pass_cnt, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_outputs", {busy, done, err, pass_cnt, fail_cnt, fail_vec}, 0);
    busy_drop = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy !== 1'b0) busy_drop++;
      tick();
    end
    check("mid_rst_stays_idle", busy_drop, 0);
    q0.push_back('{8'd8, 8'd0, 1'b0, 5'd0});
    start_run(0);
    for (int i = 0; i < 8; i++) send(3'(i));
    wait_done(11);
    tick();

    // start during CHECK must not restart the run.
    q0.push_back('{8'd8, 8'd0, 1'b0, 5'd0});
    start_run(0);
    for (int i = 0; i < 4; i++) send(3'(i));
    start = 1'b1;
    send(3'd4);
    start = 1'b0;
    for (int i = 5; i < 8; i++) send(3'(i));
    wait_done(11);
    tick();

    // rst and start together: reset wins, no run starts.
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_start_cleared", {err, pass_cnt, fail_cnt, fail_vec}, 0);
    check("rst_start_not_busy", busy, 0);
    tick();
    check("rst_start_still_idle", busy, 0);

    // Saturation instance: every vector mismatches, fail count pins at 3.
    q1.push_back('{8'd0, 8'd3, 1'b1, 5'b00011});
    start_run(1);
    for (int i = 0; i < 6; i++) send(3'(i));
    wait_done(9);

    for (int i = 0; i < 5; i++) tick();
    check("sb0_drained", q0.size(), 0);
    check("sb1_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
